// File: rtl/uart_bus_master.sv
// Host-side debug initiator: parses 'W'/'R' frames from the UART receiver, performs one
// word access on the native memory bus and streams the reply bytes to the UART transmitter.
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        core_clk_125M,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        overrun
);

  localparam logic [7:0]  CmdWrite  = 8'h57;
  localparam logic [7:0]  CmdRead   = 8'h52;
  localparam logic [7:0]  RespOk    = 8'h4B;
  localparam logic [7:0]  RespErr   = 8'h45;
  localparam logic [7:0]  RespTmo   = 8'h54;
  localparam logic [15:0] LastCycle = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        is_write_q, is_write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  // Response bytes are sent from the top byte; resp_cnt holds bytes remaining minus one.
  logic [31:0] resp_q, resp_d;
  logic [1:0]  resp_cnt_q, resp_cnt_d;
  logic [15:0] cyc_cnt_q, cyc_cnt_d;
  logic        overrun_q, overrun_d;

  // State and datapath registers; reset drops mem_valid/tx_valid without waiting for a clock.
  always_ff @(posedge core_clk_125M or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      byte_cnt_q <= 2'd0;
      is_write_q <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      resp_q     <= 32'h0;
      resp_cnt_q <= 2'd0;
      cyc_cnt_q  <= 16'd0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      resp_cnt_q <= resp_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  // Frame parser, bus sequencer and response shifter.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    resp_cnt_d = resp_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    // Bytes arriving while the bus or transmitter is occupied are dropped and flagged.
    overrun_d  = overrun_q | (rx_valid & ((state_q == StBus) | (state_q == StResp)));

    case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if ((rx_data == CmdWrite) || (rx_data == CmdRead)) begin
            is_write_d = (rx_data == CmdWrite);
            byte_cnt_d = 2'd0;
            state_d    = StAddr;
          end else begin
            resp_d     = {RespErr, 24'h0};
            resp_cnt_d = 2'd0;
            state_d    = StResp;
          end
        end
      end
      StAddr: begin
        if (rx_valid) begin
          addr_d     = {addr_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (rx_data[1:0] != 2'b00) begin
              // Misaligned: reply at once, never wait for the data bytes.
              resp_d     = {RespErr, 24'h0};
              resp_cnt_d = 2'd0;
              state_d    = StResp;
            end else if (is_write_q) begin
              state_d = StData;
            end else begin
              cyc_cnt_d = 16'd0;
              state_d   = StBus;
            end
          end
        end
      end
      StData: begin
        if (rx_valid) begin
          wdata_d    = {wdata_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            cyc_cnt_d = 16'd0;
            state_d   = StBus;
          end
        end
      end
      StBus: begin
        // A ready arriving on the final allowed cycle still wins over the timeout.
        if (mem_ready) begin
          resp_d     = is_write_q ? {RespOk, 24'h0} : mem_rdata;
          resp_cnt_d = is_write_q ? 2'd0 : 2'd3;
          state_d    = StResp;
        end else if (cyc_cnt_q == LastCycle) begin
          resp_d     = {RespTmo, 24'h0};
          resp_cnt_d = 2'd0;
          state_d    = StResp;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
      end
      StResp: begin
        if (tx_ready) begin
          if (resp_cnt_q == 2'd0) begin
            state_d = StIdle;
          end else begin
            resp_d     = {resp_q[23:0], 8'h00};
            resp_cnt_d = resp_cnt_q - 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded straight from state so that reset clears them asynchronously.
  always_comb begin
    mem_valid = (state_q == StBus);
    mem_instr = 1'b0;
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = wdata_q;
    mem_wstrb = ((state_q == StBus) && is_write_q) ? 4'hF : 4'h0;
    tx_valid  = (state_q == StResp);
    tx_data   = (state_q == StResp) ? resp_q[31:24] : 8'h00;
    busy      = (state_q != StIdle);
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: directed frames from the test plan followed by
// randomized frames, all checked against a frame-level reference model.
module tb_uart_bus_master;

  localparam int unsigned Timeout = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        overrun;

  uart_bus_master #(.TIMEOUT_CYCLES(Timeout)) dut (
    .core_clk_125M(clk),
    .resetn       (resetn),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .mem_valid    (mem_valid),
    .mem_instr    (mem_instr),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [9:0] idx);
    return {idx[7:0], 8'h5A, ~idx[7:0], 6'h0, idx[9:8]};
  endfunction

  // Bus responder: memory of 1024 words, ready after ready_delay wait cycles (-1 = never).
  logic [31:0] rmem [0:1023];
  int ready_delay = 0;
  int vcnt = 0;
  assign mem_ready = mem_valid && (ready_delay >= 0) && (vcnt == ready_delay);
  assign mem_rdata = mem_ready ? rmem[mem_addr[11:2]] : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (mem_valid && mem_ready && (mem_wstrb == 4'hF)) rmem[mem_addr[11:2]] <= mem_wdata;
    vcnt <= (mem_valid && !mem_ready) ? vcnt + 1 : 0;
  end

  // Monitor: records bus transactions, accepted tx bytes and event cycle stamps.
  int          cyc = 0;
  int          cur_len = 0;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wstrb;
  int          bus_unstable = 0;
  int          txn_len[$];
  logic [31:0] txn_addr[$];
  logic [31:0] txn_wdata[$];
  logic [3:0]  txn_wstrb[$];
  int          bus_start_cyc = 0, bus_end_cyc = 0, tx_start_cyc = 0, last_rx_cyc = 0;
  logic [7:0]  tx_q[$];
  logic        prev_stall = 1'b0, prev_tx_valid = 1'b0;
  logic [7:0]  prev_tx_data = 8'h00;
  int          tx_unstable = 0;
  int          instr_bad = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rx_valid) last_rx_cyc = cyc;
    if (mem_instr !== 1'b0) instr_bad++;
    if (mem_valid) begin
      if (cur_len == 0) begin
        cur_addr = mem_addr; cur_wdata = mem_wdata; cur_wstrb = mem_wstrb;
        bus_start_cyc = cyc;
      end else if (mem_addr !== cur_addr || mem_wdata !== cur_wdata || mem_wstrb !== cur_wstrb) begin
        bus_unstable++;
      end
      cur_len++;
      bus_end_cyc = cyc;
    end else if (cur_len > 0) begin
      txn_len.push_back(cur_len); txn_addr.push_back(cur_addr);
      txn_wdata.push_back(cur_wdata); txn_wstrb.push_back(cur_wstrb);
      cur_len = 0;
    end
    if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_tx_data)) tx_unstable++;
    if (tx_valid && !prev_tx_valid) tx_start_cyc = cyc;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    prev_stall = tx_valid && !tx_ready;
    prev_tx_data = tx_data;
    prev_tx_valid = tx_valid;
  end

  // Reference model: word memory keyed by full address plus the sticky overrun flag.
  logic [31:0] model_mem [logic [31:0]];
  bit exp_ovr = 1'b0;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_word(a[11:2]);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1; rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1; rx_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_valid"}, 32'(mem_valid), 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 0);
    check({tag, "_mem_instr"}, 32'(mem_instr), 0);
    check({tag, "_tx_valid"},  32'(tx_valid), 0);
    check({tag, "_tx_data"},   32'(tx_data), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_overrun"},   32'(overrun), 0);
  endtask

  // Sends one frame, lets the responder answer with the given delay and checks everything.
  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr,
                           input logic [31:0] data, input int delay, input bit hold);
    logic [7:0]  bytes[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] rd;
    bit legal, wr, exp_bus;
    int exp_len, waited, frame_rx_cyc;
    legal   = (cmd == 8'h57) || (cmd == 8'h52);
    wr      = (cmd == 8'h57);
    exp_bus = legal && (addr[1:0] == 2'b00);
    exp_len = 0;
    bytes.push_back(cmd);
    if (legal) for (int i = 3; i >= 0; i--) bytes.push_back(addr[8*i +: 8]);
    if (exp_bus && wr) for (int i = 3; i >= 0; i--) bytes.push_back(data[8*i +: 8]);
    if (!exp_bus) begin
      exp_tx.push_back(8'h45);
    end else if (delay < 0) begin
      exp_len = Timeout;
      exp_tx.push_back(8'h54);
    end else begin
      exp_len = delay + 1;
      if (wr) begin
        model_mem[addr] = data;
        exp_tx.push_back(8'h4B);
      end else begin
        rd = model_read(addr);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
      end
    end

    txn_len.delete(); txn_addr.delete(); txn_wdata.delete(); txn_wstrb.delete();
    tx_q.delete(); bus_unstable = 0; tx_unstable = 0;
    ready_delay = delay;
    tx_ready = !hold;
    foreach (bytes[i]) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_byte(bytes[i]);
    end
    frame_rx_cyc = last_rx_cyc;

    if (hold) begin
      waited = 0;
      while (tx_valid !== 1'b1 && waited < 200) begin @(negedge clk); waited++; end
      check("hold_tx_valid", 32'(tx_valid), 1);
      repeat (5) @(negedge clk);
      send_byte(8'h52);
      exp_ovr = 1'b1;
      repeat (14) @(negedge clk);
      check("hold_overrun", 32'(overrun), 1);
      check("hold_no_accept", tx_q.size(), 0);
      @(posedge clk); #1; tx_ready = 1'b1;
    end

    waited = 0;
    while (tx_q.size() < exp_tx.size() && waited < 400) begin
      @(negedge clk); #1; waited++;
    end
    @(negedge clk); #1;
    check("busy_after", 32'(busy), 0);
    check("tx_valid_after", 32'(tx_valid), 0);
    check("tx_count", tx_q.size(), exp_tx.size());
    foreach (exp_tx[i]) if (i < tx_q.size()) check("tx_byte", 32'(tx_q[i]), 32'(exp_tx[i]));
    check("bus_txns", txn_len.size(), 32'(exp_bus));
    if (exp_bus && txn_len.size() > 0) begin
      check("bus_len", txn_len[0], exp_len);
      check("bus_addr", txn_addr[0], addr);
      check("bus_wstrb", 32'(txn_wstrb[0]), wr ? 32'hF : 32'h0);
      if (wr) check("bus_wdata", txn_wdata[0], data);
      check("bus_start_lat", bus_start_cyc - frame_rx_cyc, 1);
      check("tx_after_bus", tx_start_cyc - bus_end_cyc, 1);
      check("bus_stable", bus_unstable, 0);
    end else if (!exp_bus) begin
      check("tx_after_rx", tx_start_cyc - frame_rx_cyc, 1);
    end
    check("tx_stable", tx_unstable, 0);
    check("overrun", 32'(overrun), 32'(exp_ovr));
    check("mem_instr", instr_bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  c;
    logic [31:0] a, d;
    int r;
    for (int i = 0; i < 1024; i++) rmem[i] = init_word(10'(i));

    #12;
    check_idle_outputs("reset");
    @(negedge clk); resetn = 1'b1;

    // Write with a combinational responder.
    run_frame(8'h57, 32'h0000_8070, 32'h0000_00A5, 0, 1'b0);
    // Read with ready delayed three cycles.
    rmem[10'h000] = 32'h1234_5678;
    model_mem[32'h0000_1000] = 32'h1234_5678;
    run_frame(8'h52, 32'h0000_1000, 32'h0, 3, 1'b0);
    // Illegal command, then a legal read of the earlier write.
    run_frame(8'h41, 32'h0, 32'h0, 0, 1'b0);
    run_frame(8'h52, 32'h0000_8070, 32'h0, 1, 1'b0);
    // Misaligned read and write.
    run_frame(8'h52, 32'h0000_8002, 32'h0, 0, 1'b0);
    run_frame(8'h57, 32'h0000_0101, 32'hCAFE_F00D, 0, 1'b0);
    // Timeout, ready never asserted.
    run_frame(8'h52, 32'h0000_2000, 32'h0, -1, 1'b0);
    // Backpressure with an overrun byte.
    run_frame(8'h52, 32'h0000_1000, 32'h0, 2, 1'b1);

    // Reset while the bus request is pending.
    ready_delay = -1;
    send_byte(8'h57);
    for (int i = 3; i >= 0; i--) send_byte(8'h00 + 8'(i == 1 ? 8'h04 : 8'h00));
    for (int i = 0; i < 4; i++) send_byte(8'h11);
    check("pre_reset_mem_valid", 32'(mem_valid), 1);
    check("pre_reset_busy", 32'(busy), 1);
    repeat (2) @(negedge clk);
    #2; resetn = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk); resetn = 1'b1;
    exp_ovr = 1'b0;

    // A later write succeeds and reads back.
    d = $urandom;
    run_frame(8'h57, 32'h0000_0300, d, 0, 1'b0);
    run_frame(8'h52, 32'h0000_0300, 32'h0, 2, 1'b0);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      d = $urandom;
      a = {20'h0, 10'($urandom_range(64, 1023)), 2'b00};
      if (r == 0) begin
        c = 8'($urandom);
        while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
        run_frame(c, a, d, 0, 1'b0);
      end else if (r == 1) begin
        a = $urandom;
        if (a[1:0] == 2'b00) a[0] = 1'b1;
        run_frame(($urandom_range(0, 1) == 0) ? 8'h57 : 8'h52, a, d, 0, 1'b0);
      end else begin
        run_frame(($urandom_range(0, 1) == 0) ? 8'h57 : 8'h52, a, d,
                  (r == 2) ? -1 : int'($urandom_range(0, 4)), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

- Host-side debug initiator: turns byte commands from the UART receiver into single-word transactions on the core's native memory bus.
- Returns the result as bytes to the UART transmitter.
- Sits beside picorv32 on the shared bus through an external arbiter. It lets a PC read and write RAM, parameter registers and GPIO without firmware involvement.

## Interface
- TIMEOUT_CYCLES, 1023: maximum cycles mem_valid stays high without mem_ready before the transaction is aborted; legal range 1..65535.
- core_clk_125M  in  1  sole clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_valid  out  1  tx_data is valid; held until accepted.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready.
- tx_data  out  8  response byte.
- mem_valid  out  1  bus request.
- mem_instr  out  1  tied 0.
- mem_ready  in  1  responder completion; may be combinational on mem_valid.
- mem_addr  out  32  word address; bits [1:0] always 0.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b1111 for writes, 4'b0000 for reads.
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky; set when rx_valid arrives in BUS or RESP. Cleared only by reset.

## Operation
- Frame format:
  - Command byte: 0x57 'W' (write) or 0x52 'R' (read).
  - Address: 4 bytes, MSB first.
  - Write frames only: 4 data bytes, MSB first.
- Responses:
  - Write: 0x4B 'K'.
  - Read: 4 rdata bytes, MSB first.
  - Illegal command byte: 0x45 'E'.
  - Address with [1:0]≠0: 0x45 'E', issued after the 4th address byte; the data bytes of such a write frame are not awaited, and no bus access occurs.
  - Timeout: 0x54 'T'.
- States:
  - IDLE: on rx_valid, a legal command goes to ADDR; any other byte loads 'E' and goes to RESP.
  - ADDR: shift in 4 bytes (byte counter 0..3).
    - After the 4th byte: misaligned → RESP('E'); read → BUS; write → DATA.
  - DATA: shift in 4 bytes, then BUS.
  - BUS: mem_valid=1 with address, wdata and wstrb stable.
    - Cycle counter starts at 0 on entry and increments each cycle without mem_ready.
    - mem_ready=1 → capture mem_rdata; load 'K' (write) or the 4 rdata bytes (read); go to RESP.
    - Counter reaches TIMEOUT_CYCLES-1 with mem_ready=0 → load 'T'; go to RESP.
    - mem_ready in the same cycle as the limit counts as success.
  - RESP: present bytes in order. Each byte advances on tx_valid && tx_ready. After the last byte is accepted, return to IDLE.
- rx_valid in BUS or RESP: byte discarded, overrun set. rx bytes in ADDR/DATA are always consumed.
- No inter-byte timeout; a partial frame waits indefinitely.

## Timing
- Reset (asynchronous):
  - State IDLE, counters 0.
  - mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, mem_instr=0.
  - tx_valid=0, tx_data=0, busy=0, overrun=0.
- Reset asserted mid-transaction drops mem_valid and tx_valid immediately. A partially sent response is lost.
- Last frame byte sampled at edge N → mem_valid=1 from edge N+1.
- mem_ready sampled 1 at edge M → mem_valid=0 from M+1. Minimum one cycle high if the responder is combinational.
- tx_valid=1 from edge M+1 with the first response byte.
- Byte k accepted at edge A → byte k+1 on tx_data from A+1, with tx_valid held high. tx_valid drops at A+1 after the last byte.
- Illegal command: tx_valid at edge after the byte is received.
- Timeout: mem_valid is high for exactly TIMEOUT_CYCLES cycles; tx_valid ('T') follows in the next cycle.
- Back-to-back frames: a new command byte is accepted in IDLE the cycle after the return to IDLE.

## Test plan
- Write 57 00 00 80 70 00 00 00 A5 with a combinational mem_ready → one mem_valid cycle with addr 0x8070, wdata 0x000000A5, wstrb 1111; tx 0x4B.
- Read 52 00 00 10 00 with mem_ready delayed 3 cycles and rdata 0x12345678 → mem_valid high 4 cycles, wstrb 0000; tx 12 34 56 78 in order.
- Command 0x41 → tx 0x45, no mem_valid; a following legal read still completes.
- Read at address 0x00008002 → tx 0x45, no mem_valid.
- Timeout: TIMEOUT_CYCLES=8, mem_ready never asserted → mem_valid high exactly 8 cycles, then tx 0x54, busy falls after acceptance.
- Backpressure: hold tx_ready=0 for 20 cycles during a read response and inject rx_valid → tx_data stable, overrun=1, all 4 bytes delivered unchanged once tx_ready rises.
- Assert resetn=0 during BUS → mem_valid and busy fall without a clock edge; a later write succeeds.
